// File: rtl/cim_pkg.sv
// cim_pkg: shared command encodings, sequencer states, default strides and ADC slice helpers
package cim_pkg;
  localparam logic [1:0] CIM_OP_WLOAD = 2'd0;
  localparam logic [1:0] CIM_OP_MVM   = 2'd1;
  localparam logic [1:0] CIM_OP_READ  = 2'd2;
  localparam int CIM_LEN_W     = 8;
  localparam int CIM_NUM_OUT   = 8;
  localparam int CIM_W_STRIDE  = 4;
  localparam int CIM_IN_STRIDE = 8;
  localparam int ADC_BYTE_W    = 8;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_CLR, S_ACC, S_FLUSH, S_OUT, S_RD} state_t;
  function automatic logic [31:0] sext_byte(input logic [ADC_BYTE_W-1:0] v);
    return {{(32-ADC_BYTE_W){v[ADC_BYTE_W-1]}}, v};
  endfunction
endpackage

// File: rtl/cim_seq_ctrl.sv
// cim_seq_ctrl: command sequencer driving the Basic_GeMM_CIM macro (weight load, MVM, byte read)
// Ports: clk/rst_n; cmd_* command stream in; din_* data beats in; res_* results out;
// busy; cim_* registered macro drive and cim_output combinational macro result.
module cim_seq_ctrl
  import cim_pkg::*;
#(
  parameter int LEN_W     = CIM_LEN_W,
  parameter int NUM_OUT   = CIM_NUM_OUT,
  parameter int W_STRIDE  = CIM_W_STRIDE,
  parameter int IN_STRIDE = CIM_IN_STRIDE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             cim_cs,
  output logic             cim_write,
  output logic             cim_en,
  output logic             cim_partial_sum,
  output logic             cim_reset_output,
  output logic [3:0]       cim_output_reg,
  output logic [31:0]      cim_address,
  output logic [31:0]      cim_input_data,
  input  logic [31:0]      cim_output
);
  state_t state;
  logic [LEN_W-1:0] cnt, len;
  logic [31:0] base;
  logic mvm;
  logic beat, last;
  assign beat = din_valid && din_ready;
  assign last = cnt == len - LEN_W'(1);
  assign busy = state != S_IDLE;
  // Reads return a byte from the macro; only that byte is meaningful.
  always_comb res_data = (state == S_RD) ? sext_byte(cim_output[ADC_BYTE_W-1:0]) : cim_output;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      base <= '0;
      mvm <= 1'b0;
      cmd_ready <= 1'b0;
      din_ready <= 1'b0;
      res_valid <= 1'b0;
      cim_cs <= 1'b0;
      cim_write <= 1'b0;
      cim_en <= 1'b0;
      cim_partial_sum <= 1'b0;
      cim_reset_output <= 1'b0;
      cim_output_reg <= '0;
      cim_address <= '0;
      cim_input_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            base <= cmd_addr;
            len <= cmd_len;
            cnt <= '0;
            mvm <= cmd_op == CIM_OP_MVM;
            // WLOAD of zero beats and the reserved op complete without leaving IDLE.
            if (cmd_op == CIM_OP_WLOAD && cmd_len != '0) begin
              state <= S_WR;
              cmd_ready <= 1'b0;
              din_ready <= 1'b1;
            end else if (cmd_op == CIM_OP_MVM) begin
              state <= S_CLR;
              cmd_ready <= 1'b0;
              cim_cs <= 1'b1;
              cim_write <= 1'b0;
              cim_en <= 1'b1;
              cim_reset_output <= 1'b1;
              cim_partial_sum <= 1'b0;
            end else if (cmd_op == CIM_OP_READ) begin
              state <= S_RD;
              cmd_ready <= 1'b0;
              cim_en <= 1'b0;
              cim_address <= cmd_addr;
              res_valid <= 1'b1;
            end
          end
        end
        S_CLR: begin
          cim_cs <= 1'b0;
          cim_reset_output <= 1'b0;
          cim_partial_sum <= 1'b1;
          din_ready <= len != '0;
          state <= (len == '0) ? S_FLUSH : S_ACC;
        end
        S_WR, S_ACC: begin
          // Cycles without an accepted beat become bubbles (cs low).
          cim_cs <= beat;
          cim_write <= state == S_WR;
          cim_en <= state == S_ACC;
          cim_partial_sum <= state == S_ACC;
          cim_reset_output <= 1'b0;
          if (beat) begin
            cim_address <= base + 32'(state == S_WR ? W_STRIDE : IN_STRIDE) * 32'(cnt);
            cim_input_data <= din_data;
            cnt <= cnt + LEN_W'(1);
            if (last) begin
              din_ready <= 1'b0;
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          cim_cs <= 1'b0;
          cim_write <= 1'b0;
          cim_partial_sum <= 1'b0;
          cim_en <= mvm;
          cim_output_reg <= '0;
          res_valid <= mvm;
          cmd_ready <= !mvm;
          state <= mvm ? S_OUT : S_IDLE;
        end
        S_OUT: if (res_valid && res_ready) begin
          if (cim_output_reg == 4'(NUM_OUT - 1)) begin
            state <= S_IDLE;
            res_valid <= 1'b0;
            cim_en <= 1'b0;
            cim_output_reg <= '0;
            cmd_ready <= 1'b1;
          end else begin
            cim_output_reg <= cim_output_reg + 4'd1;
          end
        end
        S_RD: if (res_ready) begin
          state <= S_IDLE;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cim_seq_ctrl.sv
// tb_cim_seq_ctrl: randomized directed bench for cim_seq_ctrl with a behavioural macro and reference model
module tb_cim_seq_ctrl;
  import cim_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, din_valid, din_ready, res_valid, res_ready, busy;
  logic [1:0] cmd_op;
  logic [31:0] cmd_addr, din_data, res_data, cim_address, cim_input_data, cim_output;
  logic [7:0] cmd_len;
  logic cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
  logic [3:0] cim_output_reg;
  int checks = 0;
  int failures = 0;
  int cs_cnt = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [31:0] acc [8] = '{default: 32'h0};
  logic [31:0] dq [256];
  logic [31:0] exp_res [8];
  logic [23:0] rd_hi = 24'h0;
  logic [31:0] obs;

  cim_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en), .cim_partial_sum(cim_partial_sum),
    .cim_reset_output(cim_reset_output), .cim_output_reg(cim_output_reg), .cim_address(cim_address),
    .cim_input_data(cim_input_data), .cim_output(cim_output)
  );

  always #5 clk = ~clk;

  // Macro model: byte memory, eight accumulators of nibble*weight products, byte read path
  // with junk upper bits so the sequencer's sign extension is exercised.
  always_comb cim_output = cim_en ? acc[cim_output_reg[2:0]] : {rd_hi, mem[cim_address[7:0]]};
  always @(negedge clk)
    if (cim_cs) begin
      cs_cnt++;
      if (cim_write)
        for (int b = 0; b < 4; b++) mem[8'(cim_address + 32'(b))] = cim_input_data[8*b +: 8];
      else if (cim_en && cim_reset_output)
        for (int k = 0; k < 8; k++) acc[k] = 32'h0;
      else if (cim_en && cim_partial_sum)
        for (int k = 0; k < 8; k++)
          acc[k] += 32'(cim_input_data[4*k +: 4]) * 32'(mem[8'(cim_address + 32'(k))]);
    end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit vpick(input int mode, input int c);
    return mode == 0 ? 1'b1 : mode == 2 ? (c % 2 == 0) : ($urandom_range(0, 1) == 1);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [7:0] n);
    int cyc = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = n;
    do begin @(negedge clk); cyc++; end while (!cmd_ready && cyc < 50);
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic stream(input bit wr, input logic [31:0] a, input int n, input int mode);
    int i = 0, j = 0, cyc = 0;
    bit prev_hs = 0, prev_dr = 0, hs;
    din_valid = vpick(mode, cyc); din_data = dq[0];
    while (j < n && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (prev_hs) begin
        check("beat_ctl", 32'({cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output}),
              wr ? 32'b11000 : 32'b10110);
        check("beat_addr", cim_address, a + (wr ? 32'd4 : 32'd8) * 32'(j));
        check("beat_data", cim_input_data, dq[j]);
        j++;
      end else if (prev_dr) check("bubble_cs", 32'(cim_cs), 32'd0);
      hs = din_valid && din_ready;
      if (hs) i++;
      prev_hs = hs; prev_dr = din_ready;
      @(posedge clk); #1;
      din_valid = (i < n) && vpick(mode, cyc); din_data = dq[i];
    end
    din_valid = 1'b0;
    if (j < n) check("stream_timeout", 32'(j), 32'(n));
  endtask

  task automatic run_wload(input logic [31:0] a, input int n, input int mode);
    int c0 = cs_cnt;
    issue(CIM_OP_WLOAD, a, 8'(n));
    if (n > 0) stream(1'b1, a, n, mode);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) ref_mem[8'(a + 32'(4*i + b))] = dq[i][8*b +: 8];
    @(negedge clk);
    check("wl_busy", 32'(busy), 32'd0);
    check("wl_writes", 32'(cs_cnt - c0), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic drain(input int rk);
    int k = 0, held = 0, cyc = 0;
    res_ready = (rk != 0);
    while (k < 8 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (res_valid) begin
        check("res_reg", 32'(cim_output_reg), 32'(k));
        check("res_data", res_data, exp_res[k]);
        if (res_ready) k++; else held++;
      end
      @(posedge clk); #1;
      res_ready = !(k == rk && held < 3);
    end
    if (k < 8) check("drain_timeout", 32'(k), 32'd8);
    res_ready = 1'b0;
    @(negedge clk);
    check("mvm_done", 32'({busy, res_valid, cmd_ready}), 32'b001);
    @(posedge clk); #1;
  endtask

  task automatic run_mvm(input logic [31:0] a, input int n, input int mode, input int rk);
    logic [31:0] s;
    issue(CIM_OP_MVM, a, 8'(n));
    @(negedge clk);
    check("clr_ctl", 32'({cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output}), 32'b10101);
    @(posedge clk); #1;
    if (n > 0) stream(1'b0, a, n, mode);
    for (int k = 0; k < 8; k++) begin
      s = 32'h0;
      for (int j = 0; j < n; j++)
        s += 32'(dq[j][4*k +: 4]) * 32'(ref_mem[8'(a + 32'(8*j + k))]);
      exp_res[k] = s;
    end
    drain(rk);
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] o);
    int cyc = 0;
    logic [7:0] bv;
    rd_hi = 24'($urandom);
    bv = ref_mem[a[7:0]];
    issue(CIM_OP_READ, a, 8'd0);
    while (!res_valid && cyc < 10) begin @(negedge clk); cyc++; end
    if (cyc == 0) @(negedge clk);
    o = res_data;
    check("rd_data", res_data, {{24{bv[7]}}, bv});
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    check("rd_done", 32'({busy, res_valid}), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
    din_valid = 0; din_data = 0; res_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output, cim_output_reg,
                          cmd_ready, din_ready, res_valid, busy}), 32'd0);
    check("rst_addr", cim_address, 32'd0);
    check("rst_data", cim_input_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) dq[i] = 32'h10101010;
    run_wload(32'h0, 4, 0);
    for (int i = 0; i < 2; i++) dq[i] = 32'hFFFFFFFF;
    run_mvm(32'h0, 2, 0, 99);
    run_mvm(32'h0, 2, 2, 99);
    for (int i = 0; i < 3; i++) dq[i] = $urandom;
    run_mvm(32'h0, 3, 0, 2);
    dq[0] = 32'h80556677;
    run_wload(32'h0, 1, 0);
    read(32'h3, obs);
    check("rd_neg_byte", obs, 32'hFFFFFF80);
    read(32'h1, obs);
    check("rd_pos_byte", obs, 32'h00000066);
    run_wload(32'h40, 0, 0);
    issue(2'd3, 32'h0, 8'd5);
    @(negedge clk);
    check("rsv_idle", 32'({busy, cmd_ready}), 32'b01);
    @(posedge clk); #1;
    run_mvm(32'h8, 0, 0, 99);
    for (int i = 0; i < 2; i++) dq[i] = $urandom;
    run_wload(32'hFFFFFFFC, 2, 1);
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) dq[i] = $urandom;
      run_wload($urandom, n, $urandom_range(0, 2));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) dq[i] = $urandom;
      run_mvm($urandom, n, $urandom_range(0, 2), $urandom_range(0, 8));
      read($urandom, obs);
    end
    for (int i = 0; i < 255; i++) dq[i] = $urandom;
    run_wload($urandom, 255, 0);
    for (int i = 0; i < 3; i++) dq[i] = $urandom;
    issue(CIM_OP_MVM, 32'h20, 8'd3);
    din_valid = 1'b1; din_data = dq[0];
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!din_ready && cyc < 10);
    check("acc_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1; din_data = dq[1];
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ctl", 32'({cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output, cim_output_reg,
                           cmd_ready, din_ready, res_valid, busy}), 32'd0);
    check("arst_addr", cim_address, 32'd0);
    check("arst_data", cim_input_data, 32'd0);
    din_valid = 1'b0;
    @(negedge clk);
    check("arst_idle", 32'({busy, cim_cs, din_ready}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dq[0] = $urandom;
    run_mvm(32'h20, 1, 0, 99);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
